instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory. It holds the program counter and drives the combinational ROM's Address. It captures the returned word into an IF/ID register for decode. Next-PC selection covers sequential (PC+4), taken branch and J-type jump, plus stall and flush control from the hazard logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 00.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high.
Stall  input  1  hold PC and IF/ID register.
Flush  input  1  invalidate IF/ID register.
BranchTaken  input  1  branch resolved taken this cycle.
BranchTarget  input  32  branch destination address.
Jump  input  1  J-type instruction in ID.
JumpIndex  input  26  instr_index field of the J instruction.
InstructionIn  input  32  word returned by instruction memory for Address.
Address  output  32  current PC, to instruction memory.
InstructionOut  output  32  IF/ID latched instruction.
PcOut  output  32  IF/ID latched PC.
PcPlus4Out  output  32  IF/ID latched PC+4.
Valid  output  1  IF/ID holds a live instruction.

Behaviour:
- Address is the PC register output directly. No combinational path from any input to Address.
- Reset (async assert, any time, including mid-stall or mid-redirect):
  - PC = RESET_PC.
  - InstructionOut = 0 (NOP), PcOut = 0, PcPlus4Out = 0, Valid = 0.
- After reset release, the first edge captures InstructionIn for RESET_PC, with Valid = 1.
- Latency: a word appears on InstructionOut exactly one cycle after its address is on Address.
- PcPlus4 = PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Jump target = {PcPlus4Out[31:28], JumpIndex, 2'b00}. It uses the latched PC+4 of the jump instruction in ID.
- Next PC, in priority order:
  1. BranchTaken: BranchTarget with bits [1:0] forced to 00.
  2. Jump: jump target.
  3. Stall: hold PC.
  4. Otherwise: PcPlus4.
- Redirect (BranchTaken or Jump):
  - Overrides Stall for the PC.
  - Implicitly flushes IF/ID in the same edge: Valid = 0, InstructionOut = 0. No delay slot.
  - BranchTaken and Jump together: branch wins, jump ignored.
- IF/ID update, in priority order:
  1. Flush or redirect: Valid = 0, InstructionOut = 0; PcOut/PcPlus4Out are don't-care but must be deterministic (load current PC/PcPlus4).
  2. Stall: hold all IF/ID outputs.
  3. Otherwise: InstructionOut = InstructionIn, PcOut = PC, PcPlus4Out = PcPlus4, Valid = 1.
- Flush together with Stall (no redirect): IF/ID flushed, PC holds.
- Stall held for N cycles: Address and IF/ID stay constant for N cycles, then resume at PC+4 with no skipped or duplicated fetch.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs FetchCount (32) and StallCount (32), both reset to 0 and wrapping at 2^32.
  - FetchCount increments on each edge where IF/ID loads with Valid = 1.
  - StallCount increments on each edge where Stall = 1 and no redirect occurs.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, release, run 5 cycles -> Address sequence 0x00, 0x04, 0x08, 0x0C, 0x10. InstructionOut lags one cycle (ROM words 0x24020008, 0x2403000C, ...). Valid = 1 from the first edge.
- Stall high for cycles 3-5 with Address = 0x0C -> Address stays 0x0C and InstructionOut stays 0xAC03000C for 3 cycles, then Address = 0x10.
- Jump = 1 with PcPlus4Out = 0x64 and JumpIndex = 26'h0100005 -> next Address = 0x0040_0014, Valid = 0 for one cycle. Jump with Stall = 1 must give the same result.
- BranchTaken = 1 with BranchTarget = 0x0000_0052 and Jump = 1 in the same cycle -> Address = 0x50 and InstructionOut = 0.
- Force PC to 0xFFFF_FFFC via BranchTarget, run one cycle -> Address = 0x0000_0000, PcPlus4Out = 0x0000_0000.
- Assert Reset asynchronously mid-cycle during a stall -> Address = RESET_PC and Valid = 0 immediately, without a clock edge. With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register driving the instruction ROM address, plus the IF/ID pipeline register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clock_i,
   input  logic        Reset_i,
   input  logic        Stall_i,
   input  logic        Flush_i,
   input  logic        BranchTaken_i,
   input  logic [31:0] BranchTarget_i,
   input  logic        Jump_i,
   input  logic [25:0] JumpIndex_i,
   input  logic [31:0] InstructionIn_i,
   output logic [31:0] Address_o,
   output logic [31:0] InstructionOut_o,
   output logic [31:0] PcOut_o,
   output logic [31:0] PcPlus4Out_o,
   output logic        Valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] FetchCount_o,
   output logic [31:0] StallCount_o
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] pc_plus4_out_q, pc_plus4_out_d;
   logic        valid_q, valid_d;
   logic        redirect;
   logic        kill;
   logic        load;

   assign pc_plus4    = pc_q + 32'd4;
   // Jump region comes from the PC+4 of the jump itself, which now sits in IF/ID.
   assign jump_target = {pc_plus4_out_q[31:28], JumpIndex_i, 2'b00};
   assign redirect    = BranchTaken_i | Jump_i;
   assign kill        = Flush_i | redirect;
   assign load        = !kill && !Stall_i;

   always_comb begin
      pc_d = pc_plus4;
      if (BranchTaken_i)
         pc_d = BranchTarget_i & 32'hFFFF_FFFC;
      else if (Jump_i)
         pc_d = jump_target;
      else if (Stall_i)
         pc_d = pc_q;
   end

   always_comb begin
      instr_d        = instr_q;
      pc_out_d       = pc_out_q;
      pc_plus4_out_d = pc_plus4_out_q;
      valid_d        = valid_q;
      if (kill) begin
         instr_d        = 32'h0;
         pc_out_d       = pc_q;
         pc_plus4_out_d = pc_plus4;
         valid_d        = 1'b0;
      end else if (!Stall_i) begin
         instr_d        = InstructionIn_i;
         pc_out_d       = pc_q;
         pc_plus4_out_d = pc_plus4;
         valid_d        = 1'b1;
      end
   end

   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         pc_q           <= RESET_PC;
         instr_q        <= 32'h0;
         pc_out_q       <= 32'h0;
         pc_plus4_out_q <= 32'h0;
         valid_q        <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         pc_out_q       <= pc_out_d;
         pc_plus4_out_q <= pc_plus4_out_d;
         valid_q        <= valid_d;
      end
   end

   assign Address_o        = pc_q;
   assign InstructionOut_o = instr_q;
   assign PcOut_o          = pc_out_q;
   assign PcPlus4Out_o     = pc_plus4_out_q;
   assign Valid_o          = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (load)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (Stall_i && !redirect)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign FetchCount_o = fetch_cnt_q;
   assign StallCount_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a reference model pushes the expected
// fetch state per clock edge, and each scenario task pops and compares it.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, br = 1'b0, jmp = 1'b0;
   logic [31:0] br_tgt = 32'h0;
   logic [25:0] jidx = 26'h0;
   logic [31:0] instr_in;
   logic [31:0] addr, instr_out, pc_out, pc4_out;
   logic        valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, stall_cnt;
   logic [31:0] m_fc, m_sc;
`endif

   int   errors = 0;
   int   checks = 0;
   obs_t sb[$];

   logic [31:0] m_pc, m_ins, m_pco, m_p4;
   logic        m_v;

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .Clock_i          (clk),
      .Reset_i          (rst),
      .Stall_i          (stall),
      .Flush_i          (flush),
      .BranchTaken_i    (br),
      .BranchTarget_i   (br_tgt),
      .Jump_i           (jmp),
      .JumpIndex_i      (jidx),
      .InstructionIn_i  (instr_in),
      .Address_o        (addr),
      .InstructionOut_o (instr_out),
      .PcOut_o          (pc_out),
      .PcPlus4Out_o     (pc4_out),
      .Valid_o          (valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCount_o     (fetch_cnt),
      .StallCount_o     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h00:  rom = 32'h2402_0008;
         32'h04:  rom = 32'h2403_000C;
         32'h08:  rom = 32'hAC03_000C;
         32'h0C:  rom = 32'h0062_1820;
         default: rom = {a[15:0] ^ 16'h5A5A, a[31:16]};
      endcase
   endfunction

   assign instr_in = rom(addr);

   function automatic obs_t observe();
      observe = '{addr: addr, instr: instr_out, pc: pc_out, pc4: pc4_out, valid: valid};
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_ins = 0; m_pco = 0; m_p4 = 0; m_v = 0;
`ifdef FETCH_PERF_CNT_EN
      m_fc = 0; m_sc = 0;
`endif
      sb.delete();
   endtask

   // Drive one cycle of control inputs, predict the post-edge state, then clock.
   task automatic cycle(input logic st, input logic fl, input logic b, input logic [31:0] bt,
                        input logic j, input logic [25:0] ji);
      logic [31:0] npc;
      obs_t        e;
      stall = st; flush = fl; br = b; br_tgt = bt; jmp = j; jidx = ji;
      if (b)       npc = {bt[31:2], 2'b00};
      else if (j)  npc = {m_p4[31:28], ji, 2'b00};
      else if (st) npc = m_pc;
      else         npc = m_pc + 32'd4;
      if (fl || b || j) begin
         m_ins = 0; m_v = 0; m_pco = m_pc; m_p4 = m_pc + 32'd4;
      end else if (!st) begin
         m_ins = rom(m_pc); m_v = 1; m_pco = m_pc; m_p4 = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
         m_fc = m_fc + 1;
`endif
      end
`ifdef FETCH_PERF_CNT_EN
      if (st && !(b || j)) m_sc = m_sc + 1;
`endif
      m_pc = npc;
      e = '{addr: m_pc, instr: m_ins, pc: m_pco, pc4: m_p4, valid: m_v};
      sb.push_back(e);
      @(posedge clk);
      #1;
      stall = 0; flush = 0; br = 0; jmp = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      obs_t o;
      do_reset();
      o = observe();
      checks++;
      if (o !== obs_t'{addr: RESET_PC, instr: 32'h0, pc: 32'h0, pc4: 32'h0, valid: 1'b0}) begin
         errors++;
         $display("FAIL reset_state got=%p exp addr=%h others zero", o, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      obs_t o, e;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         cycle(0, 0, 0, 0, 0, 0);
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL seq_model[%0d] got=%p exp=%p", k, o, e);
         end
         checks++;
         if (addr !== 32'(4 * k) || instr_out !== rom(32'(4 * (k - 1))) || valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_const[%0d] got addr=%h ins=%h v=%b exp addr=%h ins=%h v=1",
                     k, addr, instr_out, valid, 32'(4 * k), rom(32'(4 * (k - 1))));
         end
      end
   endtask

   task automatic test_stall();
      obs_t o, e;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 0, 0, 0);
         void'(sb.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
         cycle(1, 0, 0, 0, 0, 0);
         e = sb.pop_front();
         o = observe();
         checks++;
         if (o !== e || addr !== 32'h0C || instr_out !== 32'hAC03_000C) begin
            errors++;
            $display("FAIL stall_hold[%0d] got=%p exp=%p addr=0C ins=AC03000C", k, o, e);
         end
      end
      cycle(0, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || addr !== 32'h10 || instr_out !== 32'h0062_1820 || pc_out !== 32'h0C) begin
         errors++;
         $display("FAIL stall_resume got=%p exp=%p addr=10 ins=00621820", o, e);
      end
   endtask

   task automatic test_jump(input logic with_stall);
      obs_t o, e;
      cycle(0, 0, 1, 32'h60, 0, 0);
      void'(sb.pop_front());
      cycle(0, 0, 0, 0, 0, 0);
      void'(sb.pop_front());
      checks++;
      if (pc4_out !== 32'h64) begin
         errors++;
         $display("FAIL jump_setup got pc4=%h exp=00000064", pc4_out);
      end
      cycle(with_stall, 0, 0, 0, 1, 26'h010_0005);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || addr !== 32'h0040_0014 || valid !== 1'b0 || instr_out !== 32'h0) begin
         errors++;
         $display("FAIL jump(stall=%0b) got=%p exp=%p addr=00400014 v=0", with_stall, o, e);
      end
      cycle(0, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || valid !== 1'b1 || pc_out !== 32'h0040_0014) begin
         errors++;
         $display("FAIL jump_after(stall=%0b) got=%p exp=%p", with_stall, o, e);
      end
   endtask

   task automatic test_branch_over_jump();
      obs_t o, e;
      cycle(0, 0, 1, 32'h0000_0052, 1, 26'h3FF_FFFF);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || addr !== 32'h50 || instr_out !== 32'h0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL branch_over_jump got=%p exp=%p addr=50 ins=0", o, e);
      end
   endtask

   task automatic test_wrap();
      obs_t o, e;
      cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      void'(sb.pop_front());
      cycle(0, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || addr !== 32'h0 || pc4_out !== 32'h0 || pc_out !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL pc_wrap got=%p exp=%p addr=0 pc4=0", o, e);
      end
   endtask

   task automatic test_flush_stall();
      obs_t o, e;
      logic [31:0] held;
      cycle(0, 0, 0, 0, 0, 0);
      void'(sb.pop_front());
      held = addr;
      cycle(1, 1, 0, 0, 0, 0);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || addr !== held || valid !== 1'b0 || instr_out !== 32'h0) begin
         errors++;
         $display("FAIL flush_stall got=%p exp=%p held_addr=%h", o, e, held);
      end
      cycle(0, 1, 0, 0, 0, 0);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e || addr !== held + 32'd4 || valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_only got=%p exp=%p", o, e);
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_counters();
      checks++;
      if (fetch_cnt !== m_fc || stall_cnt !== m_sc) begin
         errors++;
         $display("FAIL perf_counters got fetch=%0d stall=%0d exp fetch=%0d stall=%0d",
                  fetch_cnt, stall_cnt, m_fc, m_sc);
      end
   endtask
`endif

   task automatic test_async_reset();
      cycle(0, 0, 0, 0, 0, 0);
      void'(sb.pop_front());
      stall = 1;
      #3;
      rst = 1;
      #1;
      checks++;
      if (addr !== RESET_PC || valid !== 1'b0 || instr_out !== 32'h0) begin
         errors++;
         $display("FAIL async_reset got addr=%h v=%b ins=%h exp addr=%h v=0 ins=0",
                  addr, valid, instr_out, RESET_PC);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_cnt got fetch=%0d stall=%0d exp 0 0", fetch_cnt, stall_cnt);
      end
`endif
      stall = 0;
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (addr !== RESET_PC + 32'd4 || valid !== 1'b1 || instr_out !== rom(RESET_PC)) begin
         errors++;
         $display("FAIL post_reset_fetch got addr=%h v=%b ins=%h", addr, valid, instr_out);
      end
      void'(sb.pop_front());
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequential();
      test_stall();
      test_jump(1'b0);
      test_jump(1'b1);
      test_branch_over_jump();
      test_wrap();
      test_flush_stall();
`ifdef FETCH_PERF_CNT_EN
      test_counters();
`endif
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
